// File: rtl/exe_mem_reg.sv
// EX/MEM pipeline register with valid/ready handshake, NOP-ing of condition-failed
// instructions, flush, and the architectural NZCV register. Optional macro: STATUS_FWD_EN.
module exe_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        cond_fail,
    input  logic        flush,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        s_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] st_val_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  status_in,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic [3:0]  dest,
    output logic [3:0]  status_q,
    output logic        carry_out
);

    logic        mem_valid_q, mem_valid_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] st_q, st_d;
    logic [3:0]  dest_q, dest_d;
    logic [3:0]  nzcv_q, nzcv_d;
    logic        accept_s;
    logic        status_upd_s;

    assign ex_ready     = !mem_valid_q || mem_ready;
    assign accept_s     = ex_valid && ex_ready;
    assign status_upd_s = accept_s && s_in && !cond_fail && !flush;

    // Next-state selection: flush beats accept, accept beats drain, otherwise hold.
    always_comb begin
        mem_valid_d = mem_valid_q;
        wb_en_d     = wb_en_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        alu_d       = alu_q;
        st_d        = st_q;
        dest_d      = dest_q;
        if (flush) begin
            mem_valid_d = 1'b0;
            wb_en_d     = 1'b0;
            mem_r_en_d  = 1'b0;
            mem_w_en_d  = 1'b0;
        end else if (accept_s) begin
            // A condition-failed instruction still occupies the slot but does nothing.
            mem_valid_d = 1'b1;
            wb_en_d     = wb_en_in    && !cond_fail;
            mem_r_en_d  = mem_r_en_in && !cond_fail;
            mem_w_en_d  = mem_w_en_in && !cond_fail;
            alu_d       = alu_result_in;
            st_d        = st_val_in;
            dest_d      = dest_in;
        end else if (mem_ready) begin
            mem_valid_d = 1'b0;
            wb_en_d     = 1'b0;
            mem_r_en_d  = 1'b0;
            mem_w_en_d  = 1'b0;
        end else begin
            mem_valid_d = mem_valid_q;
        end
        if (status_upd_s) begin
            nzcv_d = status_in;
        end else begin
            nzcv_d = nzcv_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            alu_q       <= 32'h0000_0000;
            st_q        <= 32'h0000_0000;
            dest_q      <= 4'h0;
            nzcv_q      <= 4'b0000;
        end else begin
            mem_valid_q <= mem_valid_d;
            wb_en_q     <= wb_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            alu_q       <= alu_d;
            st_q        <= st_d;
            dest_q      <= dest_d;
            nzcv_q      <= nzcv_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign alu_result = alu_q;
    assign st_val     = st_q;
    assign dest       = dest_q;
    assign status_q   = nzcv_q;

`ifdef STATUS_FWD_EN
    // Bypass the carry being written this cycle so a dependent ALU op sees it at once.
    assign carry_out = status_upd_s ? status_in[1] : nzcv_q[1];
`else
    assign carry_out = nzcv_q[1];
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Self-checking bench for exe_mem_reg: directed vector table plus a randomized
// handshake phase checked by a scoreboard queue.
module tb_exe_mem_reg;

    logic        clk;
    logic        rst, ex_valid, ex_ready, cond_fail, flush;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [3:0]  dest_in, status_in;
    logic        mem_valid, mem_ready, wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_result, st_val;
    logic [3:0]  dest, status_q;
    logic        carry_out;

    int checks   = 0;
    int failures = 0;

    exe_mem_reg dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .cond_fail(cond_fail), .flush(flush), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .s_in(s_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .status_in(status_in), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .st_val(st_val), .dest(dest),
        .status_q(status_q), .carry_out(carry_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {rst, ev, cf, fl, wb, mr, mw, s}; pre = {check, ex_ready, carry_fwd, carry_nofwd}
    // en = {mem_valid, wb_en, mem_r_en, mem_w_en} after the edge
    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] alu, st;
        logic [3:0]  dst, sin;
        logic        mrdy;
        logic [3:0]  pre;
        logic [3:0]  en;
        logic [31:0] ealu, est;
        logic [3:0]  edst, estat;
    } vec_t;

    typedef struct {
        logic [31:0] alu, st;
        logic [3:0]  dst;
        logic [2:0]  en;
    } sb_t;

    vec_t vec [16];
    sb_t  sbq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [31:0] alu, input logic [31:0] st,
                         input logic [3:0] dst, input logic [3:0] sin, input logic mrdy);
        {rst, ex_valid, cond_fail, flush, wb_en_in, mem_r_en_in, mem_w_en_in, s_in} = ctl;
        alu_result_in = alu;
        st_val_in     = st;
        dest_in       = dst;
        status_in     = sin;
        mem_ready     = mrdy;
    endtask

    initial begin
        vec[0]  = '{8'b1100_1001, 32'h1234, 32'h5678, 4'h7, 4'hF, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000};
        vec[1]  = '{8'b0000_0000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 4'b1100, 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000};
        vec[2]  = '{8'b0100_1001, 32'hFF, 32'hA5A5, 4'h3, 4'b0010, 1'b1, 4'b1110, 4'b1100, 32'hFF, 32'hA5A5, 4'h3, 4'b0010};
        vec[3]  = '{8'b0100_0101, 32'h111, 32'h222, 4'h5, 4'b1000, 1'b0, 4'b1011, 4'b1100, 32'hFF, 32'hA5A5, 4'h3, 4'b0010};
        vec[4]  = vec[3];
        vec[5]  = vec[3];
        vec[6]  = '{8'b0100_0101, 32'h111, 32'h222, 4'h5, 4'b1000, 1'b1, 4'b1101, 4'b1010, 32'h111, 32'h222, 4'h5, 4'b1000};
        vec[7]  = '{8'b0000_0000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 4'b1100, 4'b0000, 32'h111, 32'h222, 4'h5, 4'b1000};
        vec[8]  = '{8'b0110_1011, 32'h333, 32'h444, 4'h6, 4'b1111, 1'b0, 4'b1100, 4'b1000, 32'h333, 32'h444, 4'h6, 4'b1000};
        vec[9]  = '{8'b0101_1001, 32'h555, 32'h666, 4'hA, 4'b0110, 1'b0, 4'b1000, 4'b0000, 32'h333, 32'h444, 4'h6, 4'b1000};
        vec[10] = '{8'b0100_0010, 32'h777, 32'h888, 4'h9, 4'b0010, 1'b0, 4'b1100, 4'b1001, 32'h777, 32'h888, 4'h9, 4'b1000};
        vec[11] = '{8'b0100_1001, 32'h999, 32'hAAA, 4'hC, 4'b0010, 1'b0, 4'b1000, 4'b1001, 32'h777, 32'h888, 4'h9, 4'b1000};
        vec[12] = '{8'b1100_1001, 32'h999, 32'hAAA, 4'hC, 4'b0010, 1'b0, 4'b1000, 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000};
        vec[13] = '{8'b0000_0000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 4'b1100, 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000};
        vec[14] = '{8'b0100_0101, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, 4'b0010, 1'b1, 4'b1110, 4'b1010, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, 4'b0010};
        vec[15] = '{8'b0101_1001, 32'h1, 32'h2, 4'h1, 4'b0000, 1'b1, 4'b1111, 4'b0000, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, 4'b0010};

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].ctl, vec[i].alu, vec[i].st, vec[i].dst, vec[i].sin, vec[i].mrdy);
            #1;
            if (vec[i].pre[3]) begin
                chk($sformatf("v%0d ex_ready", i), {31'd0, ex_ready}, {31'd0, vec[i].pre[2]});
`ifdef STATUS_FWD_EN
                chk($sformatf("v%0d carry_out", i), {31'd0, carry_out}, {31'd0, vec[i].pre[1]});
`else
                chk($sformatf("v%0d carry_out", i), {31'd0, carry_out}, {31'd0, vec[i].pre[0]});
`endif
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid/en", i), {28'd0, mem_valid, wb_en, mem_r_en, mem_w_en}, {28'd0, vec[i].en});
            chk($sformatf("v%0d alu_result", i), alu_result, vec[i].ealu);
            chk($sformatf("v%0d st_val", i), st_val, vec[i].est);
            chk($sformatf("v%0d dest", i), {28'd0, dest}, {28'd0, vec[i].edst});
            chk($sformatf("v%0d status_q", i), {28'd0, status_q}, {28'd0, vec[i].estat});
        end

        // Randomized handshake traffic; state after the table is empty with NZCV=0010.
        begin
            logic       mv_m;
            logic [3:0] stat_m;
            logic       acc, rdy_m, upd;
            sb_t        rec;
            mv_m   = 1'b0;
            stat_m = 4'b0010;
            for (int c = 0; c < 300; c++) begin
                drive({1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 1'b0,
                       4'($urandom_range(0, 15))},
                      $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1));
                #1;
                rdy_m = !mv_m || mem_ready;
                chk("rnd ex_ready", {31'd0, ex_ready}, {31'd0, rdy_m});
                if (mv_m) begin
                    if (sbq.size() == 0) begin
                        chk("rnd scoreboard empty", 32'd0, 32'd1);
                    end else begin
                        rec = sbq[0];
                        chk("rnd alu_result", alu_result, rec.alu);
                        chk("rnd st_val", st_val, rec.st);
                        chk("rnd dest", {28'd0, dest}, {28'd0, rec.dst});
                        chk("rnd enables", {29'd0, wb_en, mem_r_en, mem_w_en}, {29'd0, rec.en});
                        if (mem_ready) void'(sbq.pop_front());
                    end
                end
                acc = ex_valid && rdy_m;
                upd = acc && s_in && !cond_fail;
`ifdef STATUS_FWD_EN
                chk("rnd carry_out", {31'd0, carry_out}, {31'd0, upd ? status_in[1] : stat_m[1]});
`else
                chk("rnd carry_out", {31'd0, carry_out}, {31'd0, stat_m[1]});
`endif
                if (acc) begin
                    rec.alu = alu_result_in;
                    rec.st  = st_val_in;
                    rec.dst = dest_in;
                    rec.en  = cond_fail ? 3'b000 : {wb_en_in, mem_r_en_in, mem_w_en_in};
                    sbq.push_back(rec);
                    mv_m = 1'b1;
                end else if (mem_ready) begin
                    mv_m = 1'b0;
                end
                if (upd) stat_m = status_in;
                @(posedge clk);
                #1;
                chk("rnd mem_valid", {31'd0, mem_valid}, {31'd0, mv_m});
                chk("rnd status_q", {28'd0, status_q}, {28'd0, stat_m});
                if (!mem_valid) begin
                    chk("rnd idle enables", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ex_valid  input  1  EX stage presents an instruction this cycle.
REQ-004 ex_ready  output  1  register can accept the EX instruction this cycle.
REQ-005 cond_fail  input  1  EX instruction failed its condition check; treat as NOP.
REQ-006 flush  input  1  invalidate register contents.
REQ-007 wb_en_in, mem_r_en_in, mem_w_en_in, s_in  input  1 each  control bits; s_in requests flag update.
REQ-008 alu_result_in  input  32  ALU result.
REQ-009 st_val_in  input  32  store data.
REQ-010 dest_in  input  4  destination register index.
REQ-011 status_in  input  4  ALU flags {N,Z,C,V} as [3:0].
REQ-012 mem_valid  output  1  MEM stage holds a valid instruction.
REQ-013 mem_ready  input  1  MEM stage consumes the held instruction this cycle.
REQ-014 wb_en, mem_r_en, mem_w_en  output  1 each  registered control bits.
REQ-015 alu_result, st_val  output  32 each  registered data.
REQ-016 dest  output  4  registered destination.
REQ-017 status_q  output  4  architectural NZCV register.
REQ-018 carry_out  output  1  carry fed back to ALU carry input.

Function
REQ-019 ex_ready SHALL equal (!mem_valid || mem_ready), purely combinational.
REQ-020 Accept = ex_valid && ex_ready; on accept all data/control SHALL load next edge and mem_valid SHALL become 1.
REQ-021 Accept with cond_fail=1 SHALL load mem_valid=1 with wb_en, mem_r_en, mem_w_en forced 0; data fields loaded but unused.
REQ-022 mem_valid && !mem_ready && !flush SHALL hold every output unchanged (stall).
REQ-023 mem_ready=1 with no accept SHALL clear mem_valid and all three enables next edge; data fields hold.
REQ-024 Simultaneous mem_ready and accept SHALL replace contents with new instruction, no bubble.
REQ-025 flush SHALL clear mem_valid and enables next edge, priority over accept and hold; data fields hold.
REQ-026 status_q SHALL load status_in only on accept with s_in=1, cond_fail=0, flush=0; otherwise hold.
REQ-027 Latency: EX inputs visible at outputs exactly one cycle after accept.
REQ-028 Enables at outputs SHALL never be 1 while mem_valid=0.

Reset
REQ-029 rst=1 at edge SHALL force mem_valid=0, enables 0, alu_result=0, st_val=0, dest=0, status_q=4'b0000, priority over flush, accept, stall.
REQ-030 Reset mid-stall SHALL discard held instruction; ex_ready=1 cycle after.

Configuration
REQ-031 Macro STATUS_FWD_EN defined: carry_out SHALL equal status_in[1] in any cycle where REQ-026 update conditions hold, else status_q[1].
REQ-032 Macro STATUS_FWD_EN undefined: carry_out SHALL equal status_q[1] always; no combinational path from status_in.

Verification
REQ-033 rst 1 cycle -> mem_valid=0, status_q=0000, alu_result=0, ex_ready=1.
REQ-034 accept alu_result_in=32'h0000_00FF, dest=4'h3, wb_en_in=1, s_in=1, status_in=4'b0010, mem_ready=1 -> next cycle alu_result=FF, dest=3, wb_en=1, status_q=0010, carry_out=1.
REQ-035 mem_valid=1, mem_ready=0 three cycles, ex_valid=1 new data -> outputs hold, ex_ready=0; mem_ready=1 -> new data loads next edge, no bubble.
REQ-036 accept cond_fail=1, s_in=1, mem_w_en_in=1, status_in=1111 -> mem_valid=1, mem_w_en=0, status_q unchanged.
REQ-037 flush with ex_valid=1, s_in=1 during stall -> mem_valid=0, enables 0, status_q unchanged.
REQ-038 STATUS_FWD_EN defined, status_q[1]=0, accept s_in=1, status_in[1]=1 -> carry_out=1 same cycle; undefined -> carry_out=0 until next edge.
